// File: rtl/mem_stage_pkg.sv
// Op codes, FSM encoding and op-decoding helpers shared by the MEM stage.
package mem_stage_pkg;

  localparam int ALU_OP_W = 8;

  localparam logic [ALU_OP_W-1:0] MEM_NOP = 8'h00;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 8'h20;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 8'h24;
  localparam logic [ALU_OP_W-1:0] MEM_LB  = 8'h40;
  localparam logic [ALU_OP_W-1:0] MEM_LH  = 8'h41;
  localparam logic [ALU_OP_W-1:0] MEM_LW  = 8'h42;
  localparam logic [ALU_OP_W-1:0] MEM_LBU = 8'h43;
  localparam logic [ALU_OP_W-1:0] MEM_LHU = 8'h44;
  localparam logic [ALU_OP_W-1:0] MEM_SB  = 8'h48;
  localparam logic [ALU_OP_W-1:0] MEM_SH  = 8'h49;
  localparam logic [ALU_OP_W-1:0] MEM_SW  = 8'h4A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_t;

  function automatic logic [2:0] op_size(input logic [ALU_OP_W-1:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
      MEM_LW, MEM_SW:          return 3'd4;
      default:                 return 3'd0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [ALU_OP_W-1:0] op);
    return (op_size(op) != 3'd0);
  endfunction

  function automatic logic is_load_op(input logic [ALU_OP_W-1:0] op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ld_ext.sv
// Sign/zero extension of the little-endian packed load bytes according to the load op.
module mem_ld_ext
  import mem_stage_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [31:0]         raw,
  output logic [31:0]         ext
);

  // Pick the extension rule from the load width and signedness.
  always_comb begin
    ext = raw;
    case (op)
      MEM_LB:  ext = {{24{raw[7]}}, raw[7:0]};
      MEM_LBU: ext = {24'h000000, raw[7:0]};
      MEM_LH:  ext = {{16{raw[15]}}, raw[15:0]};
      MEM_LHU: ext = {16'h0000, raw[15:0]};
      MEM_LW:  ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: byte-serial loads/stores over a shared 8-bit RAM port, stalling the
// pipeline until the access is complete; non-memory results pass straight through.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [31:0]           mem_addr_i,
  input  logic                  mem_hold_i,
  input  logic                  mem_gnt_i,
  input  logic [7:0]            mem_din_i,
  output logic [MEM_ADDR_W-1:0] mem_a_o,
  output logic [7:0]            mem_dout_o,
  output logic                  mem_wr_o,
  output logic [4:0]            wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req_o
);

  mem_state_t            state_r;
  logic [2:0]            idx_r;
  logic [2:0]            size_r;
  logic                  is_load_r;
  logic [ALU_OP_W-1:0]   op_r;
  logic [MEM_ADDR_W-1:0] addr_r;
  logic [31:0]           st_data_r;
  logic [31:0]           ld_data_r;
  logic [4:0]            wd_r;
  logic                  pend_r;
  logic [1:0]            pend_idx_r;
  logic [31:0]           ld_ext_s;

  mem_ld_ext u_ld_ext (
    .op  (op_r),
    .raw (ld_data_r),
    .ext (ld_ext_s)
  );

  // Access sequencer; a read issued in one cycle returns its byte in the next, tracked by pend_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      size_r     <= 3'd0;
      is_load_r  <= 1'b0;
      op_r       <= MEM_NOP;
      addr_r     <= {MEM_ADDR_W{1'b0}};
      st_data_r  <= 32'h0000_0000;
      ld_data_r  <= 32'h0000_0000;
      wd_r       <= 5'd0;
      pend_r     <= 1'b0;
      pend_idx_r <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mem_op(aluop_i)) begin
            idx_r     <= 3'd0;
            size_r    <= op_size(aluop_i);
            is_load_r <= is_load_op(aluop_i);
            op_r      <= aluop_i;
            addr_r    <= mem_addr_i[MEM_ADDR_W-1:0];
            st_data_r <= wdata_i;
            ld_data_r <= 32'h0000_0000;
            wd_r      <= wd_i;
            pend_r    <= 1'b0;
            state_r   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (pend_r) begin
            ld_data_r[{pend_idx_r, 3'b000} +: 8] <= mem_din_i;
          end
          pend_r <= 1'b0;
          if (mem_gnt_i) begin
            idx_r      <= idx_r + 3'd1;
            pend_r     <= is_load_r;
            pend_idx_r <= idx_r[1:0];
            if (idx_r == size_r - 3'd1) begin
              state_r <= is_load_r ? ST_WAIT : ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (pend_r) begin
            ld_data_r[{pend_idx_r, 3'b000} +: 8] <= mem_din_i;
          end
          pend_r  <= 1'b0;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          if (!mem_hold_i) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'h0000_0000;
    stall_req_o = 1'b0;
    mem_a_o     = {MEM_ADDR_W{1'b0}};
    mem_dout_o  = 8'h00;
    mem_wr_o    = 1'b0;
    if (rst) begin
      stall_req_o = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mem_op(aluop_i)) begin
            stall_req_o = 1'b1;
          end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        ST_ACCESS: begin
          stall_req_o = 1'b1;
          mem_a_o     = addr_r + MEM_ADDR_W'(idx_r);
          if (mem_gnt_i && !is_load_r) begin
            mem_wr_o   = 1'b1;
            mem_dout_o = st_data_r[{idx_r[1:0], 3'b000} +: 8];
          end else begin
            mem_wr_o = 1'b0;
          end
        end
        ST_WAIT: stall_req_o = 1'b1;
        ST_DONE: begin
          if (is_load_r) begin
            wd_o    = wd_r;
            wreg_o  = wreg_i;
            wdata_o = ld_ext_s;
          end else begin
            wreg_o = 1'b0;
          end
        end
        default: stall_req_o = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline; sits between the ex_mem pipeline register and the mem_wb register.
- Non-memory results pass through unchanged.
- Loads and stores run as a byte-serial sequence on the single 8-bit RAM port. The pipeline stalls until the access completes.
- Loads are sign- or zero-extended before being handed to write-back.

Parameters:
- MEM_ADDR_W, 32: width of mem_a_o; the byte address is truncated to its low MEM_ADDR_W bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (`RstEnable)
- wd_i  in  5  destination register from ex_mem
- wreg_i  in  1  write-enable from ex_mem
- wdata_i  in  32  ALU result, or store data for stores
- aluop_i  in  `AluOpBus  memory op: `MEM_NOP, LB/LH/LW/LBU/LHU/SB/SH/SW
- mem_addr_i  in  32  effective byte address
- mem_hold_i  in  1  MEM stage frozen by the stall controller this cycle
- mem_gnt_i  in  1  RAM port granted to this stage this cycle (arbiter shared with IF)
- mem_din_i  in  8  RAM read byte
- mem_a_o  out  MEM_ADDR_W  RAM byte address
- mem_dout_o  out  8  RAM write byte
- mem_wr_o  out  1  RAM write strobe
- wd_o  out  5  to mem_wb
- wreg_o  out  1  to mem_wb
- wdata_o  out  32  to mem_wb
- stall_req_o  out  1  stall request to the stall controller

Behaviour:
- Reset: state=IDLE; idx=0; captured data=0. While rst=1, every output is 0.
- A reset mid-operation aborts the sequence. Bytes already written stay written.
- States: IDLE, ACCESS, WAIT, DONE.
- Size n: 1 for B/BU, 2 for H/HU, 4 for W.
- Misaligned addresses are legal.
- Byte addresses are mem_addr+idx, modulo 2^MEM_ADDR_W.
- Byte order is little-endian.

IDLE:
- Non-memory aluop: wd_o/wreg_o/wdata_o = inputs (combinational); stall_req_o=0; mem_wr_o=0.
- Memory op: stall_req_o=1; latch addr, size, sign, store data, wd; idx=0; go to ACCESS.

ACCESS:
- stall_req_o=1.
- mem_a_o = addr+idx.
- Store: mem_wr_o=1 when mem_gnt_i=1, with mem_dout_o = data[8*idx+7:8*idx].
- mem_gnt_i=1: idx increments.
- mem_gnt_i=0: nothing issues and idx holds.
- Load capture: a byte issued in cycle k appears on mem_din_i in cycle k+1 and is captured at the end of k+1, whether or not a grant occurs in k+1.
- Last byte issued: a store goes to DONE; a load goes to WAIT.

WAIT:
- stall_req_o=1; mem_wr_o=0.
- Capture the final byte, then go to DONE.

DONE:
- stall_req_o=0.
- Load: wreg_o=wreg_i, wd_o=latched wd, wdata_o=extended load value.
- Store: wreg_o=0, wd_o=0, wdata_o=0.
- mem_hold_i=1: stay in DONE with outputs stable.
- mem_hold_i=0: go to IDLE. The pipeline advances on this same edge.

Timing with grant held high:
- LB/LBU: 3 stall cycles, result in cycle 4.
- LH/LHU: 4 stall cycles, result in cycle 5.
- LW: 6 stall cycles, result in cycle 7.
- SB: 2 stall cycles. SH: 3 stall cycles. SW: 5 stall cycles.
- Each cycle with the grant low adds one cycle.

Other rules:
- Stores issue regardless of wreg_i.
- mem_wr_o is never high outside ACCESS.
- An op arriving in DONE is ignored until IDLE. Upstream holds ex_mem steady while stall_req_o=1.

Decomposition:
- defines.v gains `MEM_* op codes, the state encodings (2 bits) and `MemAddrBus.
- One sub-module, mem_ld_ext (combinational): packs the captured bytes, then sign- or zero-extends them by op.

Test Plan:
- ADD pass-through, wd=5, wdata=0x1234 → same cycle wd_o=5, wdata_o=0x1234, stall_req_o=0, mem_wr_o=0.
- LB at 0x100, RAM[0x100]=0x80, grant high → stall_req_o high 3 cycles; then wdata_o=0xFFFFFF80. LBU gives 0x00000080.
- SW 0xDEADBEEF at 0x203, grant high → writes 0xEF,0xBE,0xAD,0xDE at 0x203..0x206 in 4 consecutive cycles; stall 5 cycles; wreg_o=0.
- LW at 0x10 with grant low in the 2nd issue cycle → address 0x11 re-presented next cycle; result 0x44332211 from bytes 11,22,33,44; latency 7 cycles.
- LH done while mem_hold_i=1 for 3 cycles → DONE holds wdata_o stable, no new RAM access; IDLE after hold drops.
- rst asserted during 3rd byte of SW → next cycle all outputs 0, state IDLE, no further mem_wr_o pulses.
